writeback_stage: RTL and testbench
==================================

# writeback_stage

Writeback stage of the RISC-V core, directly upstream of `registers_bank`. It merges single-cycle ALU results and buffered load returns into the register file's single write port and drives `we` / `sel_in` / `data_in`. Load data is aligned and sign- or zero-extended before the write. A starvation guard keeps a steady ALU stream from blocking loads indefinitely.

## Interface
- `XLEN`, 32, data width
- `REG_ADDR_W`, 5, register index width
- `LD_FIFO_DEPTH`, 2, load return buffer entries (power of two, ≥2)
- `STARVE_MAX`, 3, consecutive ALU wins allowed while a load waits
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` is high
- `alu_rd`  in  REG_ADDR_W  ALU destination
- `alu_data`  in  XLEN  ALU result
- `ld_valid`  in  1  load return offered
- `ld_ready`  out  1  FIFO has space
- `ld_rd`  in  REG_ADDR_W  load destination
- `ld_funct3`  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- `ld_byte_off`  in  2  address[1:0]
- `ld_word`  in  XLEN  raw memory word
- `rf_we`  out  1  to `registers_bank.we`
- `rf_sel_in`  out  REG_ADDR_W  to `registers_bank.sel_in`
- `rf_data_in`  out  XLEN  to `registers_bank.data_in`
- `ld_pending`  out  1  FIFO non-empty (hazard unit stalls on it)

## Operation
- Load transfer: `ld_valid && ld_ready` pushes {rd, funct3, byte_off, word}. `ld_ready` = !full. There is no bypass when full, even if a pop happens in the same cycle.
- ALU transfer: `alu_valid && alu_ready`. The ALU side has no buffer; an accepted result is written the next cycle.
- Arbitration each cycle, one write at most:
  - ALU wins when `alu_valid` is high and the guard is not forcing.
  - Otherwise the FIFO head pops if the FIFO is non-empty.
- Starvation guard: counter `starve_cnt`.
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on a load pop or when the FIFO is empty.
  - At `starve_cnt == STARVE_MAX`: `alu_ready` = 0 and the head pops.
  - Otherwise `alu_ready` = 1.
- Alignment of the head word `w`, offset `o`:
  - LB/LBU: byte `w[8o+7:8o]`
  - LH/LHU: half `w[16·o[1]+15:16·o[1]]`; `o[0]` ignored
  - LW: `w`; offset ignored
  - Sign-extend LB/LH, zero-extend LBU/LHU. Any other funct3 is treated as LW.
- rd = x0: the transfer completes and the FIFO pops normally, but `rf_we` stays 0 and the guard counts as usual.

## Timing
- Reset values: `rf_we` 0, `rf_sel_in` 0, `rf_data_in` 0, `ld_pending` 0, FIFO empty, `starve_cnt` 0.
- Because the FIFO is empty after reset, `ld_ready` is 1 and `alu_ready` is 1.
- `rf_*` are registered. A winner selected in cycle N appears on `rf_*` in cycle N+1 for exactly one cycle.
- ALU latency: accept at N → `rf_we` at N+1.
- Load latency: push at N → earliest pop at N+1 → `rf_we` at N+2.
- FIFO ordering is strict: loads are written in arrival order.
- Simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged.
- Pointers wrap modulo `LD_FIFO_DEPTH`.
- Reset mid-operation: buffered loads are dropped, and any `rf_we` pending for the next cycle is suppressed.

## Configuration
- `WB_STARVE_GUARD_EN` defined: the guard operates as described above.
- Undefined: `starve_cnt` is removed, `alu_ready` is tied to 1, and the ALU has strict priority. Loads drain only in cycles where `alu_valid` is low.

## Structure
- Shared package `wb_pkg` holds:
  - funct3 load encodings (`LD_LB` … `LD_LHU`)
  - `XLEN` / `REG_ADDR_W` defaults
  - the FIFO entry struct type
- Sub-module `load_align`: combinational; {funct3, byte_off, word} → XLEN result.
- FIFO and arbiter are inline in `writeback_stage`.

## Test plan
- Reset held 3 cycles, then released with no traffic → `rf_we` 0, `ld_ready` 1, `alu_ready` 1, `ld_pending` 0.
- ALU rd=5, data 0x1234 accepted at N → `rf_we` 1, `rf_sel_in` 5, `rf_data_in` 0x1234 at N+1 only.
- Loads with word 0x80FF7F01:
  - LB off=3 → 0xFFFFFF80
  - LBU off=3 → 0x00000080
  - LH off=2 → 0xFFFF80FF
  - LHU off=0 → 0x00007F01
  - LW → 0x80FF7F01
- ALU rd=0 data 7 → accepted, `rf_we` stays 0.
- Continuous `alu_valid` with one load buffered, guard enabled → 3 ALU writes, then `alu_ready` 0 for one cycle and the load is written. With guard disabled, the load waits until `alu_valid` drops.
- Push 2 loads while `alu_valid` is held high → `ld_ready` 0. Assert reset mid-stream → FIFO empties, `ld_pending` 0, no stale `rf_we`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage.
// Load funct3 codes, width defaults, FIFO entry.
package wb_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [2:0]                funct3;
    logic [1:0]                byte_off;
    logic [XLEN_DEF-1:0]       word;
  } ld_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment and sign/zero extension.
// Unknown funct3 values fall back to a full word.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{byte_off, 3'b000} +: 8];
  assign h = word[{byte_off[1], 4'b0000} +: 16];

  // select lane and extend according to load type
  always_comb begin
    result = word;
    unique case (1'b1)
      (funct3 == LD_LB):  result = {{(XLEN-8){b[7]}}, b};
      (funct3 == LD_LBU): result = {{(XLEN-8){1'b0}}, b};
      (funct3 == LD_LH):  result = {{(XLEN-16){h[15]}}, h};
      (funct3 == LD_LHU): result = {{(XLEN-16){1'b0}}, h};
      default:            result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback: ALU results and buffered loads share the RF write port.
// Optional starvation guard enabled by WB_STARVE_GUARD_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int LD_FIFO_DEPTH = 2,
  parameter int STARVE_MAX    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_byte_off,
  input  logic [XLEN-1:0]       ld_word,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_sel_in,
  output logic [XLEN-1:0]       rf_data_in,
  output logic                  ld_pending
);

  localparam int PW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = PW + 1;

  ld_entry_t mem_q [LD_FIFO_DEPTH];
  ld_entry_t push_entry;
  ld_entry_t head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty, full;
  logic push, pop;
  logic alu_win, force_ld;

  logic [XLEN-1:0] ld_aligned;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_sel_q, rf_sel_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(LD_FIFO_DEPTH));

  assign ld_ready   = !full;
  assign ld_pending = !empty;
  assign push       = ld_valid && !full;

  assign push_entry = '{
    rd:       ld_rd,
    funct3:   ld_funct3,
    byte_off: ld_byte_off,
    word:     ld_word
  };

  assign head = mem_q[rd_ptr_q];

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign force_ld = !empty &&
                    (starve_cnt_q == SW'(STARVE_MAX));

  // count ALU wins while a load is waiting
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || empty)
      starve_cnt_d = '0;
    else if (alu_win)
      starve_cnt_d = starve_cnt_q + SW'(1);
  end

  // guard counter register
  always_ff @(posedge clock) begin
    if (reset)
      starve_cnt_q <= '0;
    else
      starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_starve_max;

  assign force_ld          = 1'b0;
  assign unused_starve_max = ^STARVE_MAX;
`endif

  assign alu_ready = !force_ld;
  assign alu_win   = alu_valid && !force_ld;
  assign pop       = !alu_win && !empty;

  load_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3   (head.funct3),
    .byte_off (head.byte_off),
    .word     (head.word),
    .result   (ld_aligned)
  );

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= push_entry;
  end

  // select the single write for next cycle; x0 writes are dropped
  always_comb begin
    rf_we_d   = 1'b0;
    rf_sel_d  = rf_sel_q;
    rf_data_d = rf_data_q;
    if (alu_win) begin
      rf_we_d   = (alu_rd != '0);
      rf_sel_d  = alu_rd;
      rf_data_d = alu_data;
    end else if (pop) begin
      rf_we_d   = (head.rd != '0);
      rf_sel_d  = head.rd;
      rf_data_d = ld_aligned;
    end
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_sel_q  <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rf_we_q   <= rf_we_d;
      rf_sel_q  <= rf_sel_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_sel_in  = rf_sel_q;
  assign rf_data_in = rf_data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed steps then random
// traffic against a queue-based reference model.
module tb_writeback_stage;

  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 3;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [RW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [RW-1:0]   ld_rd = '0;
  logic [2:0]      ld_funct3 = '0;
  logic [1:0]      ld_byte_off = '0;
  logic [XLEN-1:0] ld_word = '0;
  logic            rf_we;
  logic [RW-1:0]   rf_sel_in;
  logic [XLEN-1:0] rf_data_in;
  logic            ld_pending;

  always #5 clock = ~clock;

  writeback_stage #(
    .XLEN          (XLEN),
    .REG_ADDR_W    (RW),
    .LD_FIFO_DEPTH (DEPTH),
    .STARVE_MAX    (SMAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_funct3   (ld_funct3),
    .ld_byte_off (ld_byte_off),
    .ld_word     (ld_word),
    .rf_we       (rf_we),
    .rf_sel_in   (rf_sel_in),
    .rf_data_in  (rf_data_in),
    .ld_pending  (ld_pending)
  );

  typedef struct {
    logic [RW-1:0]   rd;
    logic [2:0]      f3;
    logic [1:0]      off;
    logic [XLEN-1:0] w;
  } ld_t;

  ld_t         q[$];
  int          starve = 0;
  logic        exp_we;
  logic [4:0]  exp_sel;
  logic [31:0] exp_data;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(
    input logic [2:0] f3, input logic [1:0] off,
    input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * int'(off))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> ((off >= 2'd2) ? 16 : 0)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One clock of traffic, predicted by the model and checked.
  task automatic cycle(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv,
                       input ld_t e);
    bit   mt, fl, forced, aw, pp;
    ld_t  h;
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    ld_valid    = lv;
    ld_rd       = e.rd;
    ld_funct3   = e.f3;
    ld_byte_off = e.off;
    ld_word     = e.w;
    #2;
    mt     = (q.size() == 0);
    fl     = (q.size() == DEPTH);
    forced = GUARD && !mt && (starve == SMAX);
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, !fl});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, !forced});
    aw = av && !forced;
    pp = !aw && !mt;
    exp_we = 1'b0;
    if (aw) begin
      exp_we   = (ard != 0);
      exp_sel  = ard;
      exp_data = ad;
    end else if (pp) begin
      h        = q.pop_front();
      exp_we   = (h.rd != 0);
      exp_sel  = h.rd;
      exp_data = ref_align(h.f3, h.off, h.w);
    end
    if (pp || mt) starve = 0;
    else if (aw) starve++;
    if (lv && !fl) q.push_back(e);
    @(posedge clock);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("rf_sel_in", {27'd0, rf_sel_in}, {27'd0, exp_sel});
      chk("rf_data_in", rf_data_in, exp_data);
    end
    chk("ld_pending", {31'd0, ld_pending},
        {31'd0, q.size() != 0});
  endtask

  ld_t         z;
  ld_t         e;
  int          first;
  logic [2:0]  lf3 [5];
  logic [1:0]  loff[5];
  logic [31:0] lexp[5];

  initial begin
    z = '{rd: '0, f3: '0, off: '0, w: '0};
    lf3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    loff = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    lexp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
             32'h00007F01, 32'h80FF7F01};

    // reset held three cycles
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_sel", {27'd0, rf_sel_in}, 32'd0);
    chk("rst_data", rf_data_in, 32'd0);
    chk("rst_pending", {31'd0, ld_pending}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    cycle(0, 0, 0, 0, z);

    // single ALU write, visible for exactly one cycle
    cycle(1, 5, 32'h1234, 0, z);
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_sel", {27'd0, rf_sel_in}, 32'd5);
    chk("alu_data", rf_data_in, 32'h1234);
    cycle(0, 0, 0, 0, z);
    chk("alu_we_once", {31'd0, rf_we}, 32'd0);

    // load alignment table
    for (int i = 0; i < 5; i++) begin
      e = '{rd: 5'(3 + i), f3: lf3[i], off: loff[i],
            w: 32'h80FF7F01};
      cycle(0, 0, 0, 1, e);
      chk("ld_lat_we0", {31'd0, rf_we}, 32'd0);
      cycle(0, 0, 0, 0, z);
      chk("ld_align", rf_data_in, lexp[i]);
    end

    // ALU write to x0 is accepted but not written
    cycle(1, 0, 32'd7, 0, z);
    chk("x0_we", {31'd0, rf_we}, 32'd0);

    // ALU stream vs one buffered load
    e = '{rd: 5'd9, f3: 3'b010, off: 2'd0, w: 32'hCAFE0009};
    cycle(1, 1, 32'hA0, 1, e);
    first = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 32'(i), 0, z);
      if (first < 0 && rf_we && rf_sel_in == 5'd9) first = i;
    end
    chk("starve_slot", 32'(first), GUARD ? 32'd3 : 32'hFFFFFFFF);
    cycle(0, 0, 0, 0, z);
    cycle(0, 0, 0, 0, z);

    // fill FIFO under ALU pressure, then reset mid-stream
    e = '{rd: 5'd10, f3: 3'b000, off: 2'd1, w: 32'h11223344};
    cycle(1, 2, 32'hB0, 1, e);
    e = '{rd: 5'd11, f3: 3'b101, off: 2'd2, w: 32'h55667788};
    cycle(1, 2, 32'hB1, 1, e);
    chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    q.delete();
    starve = 0;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_pending", {31'd0, ld_pending}, 32'd0);
    chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    reset = 1'b0;
    cycle(0, 0, 0, 0, z);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      e = '{rd:  5'($urandom_range(0, 31)),
            f3:  3'($urandom_range(0, 7)),
            off: 2'($urandom_range(0, 3)),
            w:   $urandom};
      cycle($urandom_range(0, 99) < 65,
            5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 50, e);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, z);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
